// File: rtl/addr_stack_arbiter.sv
// addr_stack_arbiter
// Shares a shallow address stack between NUM_REQ spike-address sources and a
// single consumer. One command per cycle (pop, push-single, push-dual). Pop wins
// over pushes. Pushes are served round-robin. A mirrored occupancy count keeps
// the stack from overflowing or underflowing.
// Optional macro ADDR_ARB_BYPASS_EN: a blocked dual head may be bypassed by a
// fitting single request, at most twice in a row.
module addr_stack_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 16,
   parameter int STACK_SIZE = 3
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ-1:0]            req_dual,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic                          pop_req,
   input  logic                          stk_wait,
   output logic [NUM_REQ-1:0]            gnt,
   output logic                          stk_en,
   output logic [1:0]                    stk_ctl,
   output logic [DATA_WIDTH-1:0]         stk_data,
   output logic                          pop_ack,
   output logic [1:0]                    occupancy,
   output logic                          busy
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   localparam logic [1:0] CTL_POP   = 2'b00;
   localparam logic [1:0] CTL_PUSH1 = 2'b01;
   localparam logic [1:0] CTL_PUSH2 = 2'b11;

   // Next source index in round-robin order, wrapping at NUM_REQ.
   function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] idx);
      return (idx == PTR_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
   endfunction

   // First set bit of mask scanning from start; MSB of the result is "found".
   function automatic logic [PTR_W:0] find_first(input logic [NUM_REQ-1:0] mask,
                                                 input logic [PTR_W-1:0]   start);
      logic [PTR_W:0]   res;
      logic [PTR_W-1:0] idx;
      res = '0;
      idx = start;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (mask[idx] && !res[PTR_W]) res = {1'b1, idx};
         idx = next_idx(idx);
      end
      return res;
   endfunction

   logic                  armed;      // low on the first edge after reset release
   logic [PTR_W-1:0]      rr_ptr;
   logic [NUM_REQ-1:0]    eligible;
   logic                  head_found;
   logic [PTR_W-1:0]      head_idx;
   logic                  single_fit;
   logic                  dual_fit;
   logic                  head_fits;
   logic                  grant_fire;
   logic [PTR_W-1:0]      grant_idx;
   logic                  grant_dual;
   logic                  do_push;
   logic [NUM_REQ-1:0]    nxt_gnt;
   logic                  nxt_en;
   logic [1:0]            nxt_ctl;
   logic [DATA_WIDTH-1:0] nxt_data;
   logic                  nxt_ack;
   logic [1:0]            nxt_occ;
   logic [PTR_W-1:0]      nxt_ptr;

`ifdef ADDR_ARB_BYPASS_EN
   logic [1:0]            byp_cnt;
   logic                  byp_found;
   logic [PTR_W-1:0]      byp_idx;
   logic                  byp_take;
`endif

   // A source whose grant is currently showing is not eligible again yet.
   assign eligible = req & ~gnt;
   assign {head_found, head_idx} = find_first(eligible, rr_ptr);

   assign single_fit = occupancy < 2'(STACK_SIZE);
   assign dual_fit   = ({1'b0, occupancy} + 3'd2) <= 3'(STACK_SIZE);
   assign head_fits  = req_dual[head_idx] ? dual_fit : single_fit;

`ifdef ADDR_ARB_BYPASS_EN
   // Only single requests behind the head are bypass candidates.
   assign {byp_found, byp_idx} = find_first(eligible & ~req_dual, next_idx(head_idx));
`endif

   // Pick the push grantee: the round-robin head, or a bypassing single.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      grant_fire = 1'b0;
      grant_idx  = head_idx;
`ifdef ADDR_ARB_BYPASS_EN
      byp_take   = 1'b0;
`endif
      if (head_found) begin
         if (head_fits) begin
            grant_fire = 1'b1;
         end
`ifdef ADDR_ARB_BYPASS_EN
         else if (req_dual[head_idx] && byp_cnt < 2'd2 && single_fit && byp_found) begin
            grant_fire = 1'b1;
            grant_idx  = byp_idx;
            byp_take   = 1'b1;
         end
`endif
      end
   end

   assign grant_dual = req_dual[grant_idx];

   // Per-cycle command decision: stall, then pop, then push.
   always_comb begin
      nxt_gnt  = '0;
      nxt_en   = 1'b0;
      nxt_ctl  = CTL_POP;
      nxt_data = '0;
      nxt_ack  = 1'b0;
      nxt_occ  = occupancy;
      nxt_ptr  = rr_ptr;
      do_push  = 1'b0;
      if (armed && !stk_wait) begin
         if (pop_req && occupancy != 2'd0) begin
            nxt_en  = 1'b1;
            nxt_ack = 1'b1;
            nxt_occ = occupancy - 2'd1;
         end else if (grant_fire) begin
            do_push            = 1'b1;
            nxt_gnt[grant_idx] = 1'b1;
            nxt_en             = 1'b1;
            nxt_ctl            = grant_dual ? CTL_PUSH2 : CTL_PUSH1;
            nxt_data           = req_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
            nxt_occ            = occupancy + (grant_dual ? 2'd2 : 2'd1);
            nxt_ptr            = next_idx(grant_idx);
         end
      end
   end

   // Register all outputs and arbitration state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armed     <= 1'b0;
         rr_ptr    <= '0;
         gnt       <= '0;
         stk_en    <= 1'b0;
         stk_ctl   <= CTL_POP;
         stk_data  <= '0;
         pop_ack   <= 1'b0;
         occupancy <= 2'd0;
         busy      <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         armed     <= 1'b1;
         rr_ptr    <= nxt_ptr;
         gnt       <= nxt_gnt;
         stk_en    <= nxt_en;
         stk_ctl   <= nxt_ctl;
         stk_data  <= nxt_data;
         pop_ack   <= nxt_ack;
         occupancy <= nxt_occ;
         busy      <= (nxt_occ != 2'd0) || (|req);
      end
   end

`ifdef ADDR_ARB_BYPASS_EN
   // Count consecutive bypasses; any head grant clears the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       byp_cnt <= 2'd0;
      else if (do_push) byp_cnt <= byp_take ? byp_cnt + 2'd1 : 2'd0;
   end
`endif

endmodule

// File: tb/tb_addr_stack_arbiter.sv
// Bench for addr_stack_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a queue-based
// reference model of the arbitration rules.
module tb_addr_stack_arbiter;

   localparam int N  = 4;
   localparam int DW = 16;
   localparam int SS = 3;

   logic            clk      = 1'b0;
   logic            rst_n    = 1'b0;
   logic [N-1:0]    req      = '0;
   logic [N-1:0]    req_dual = '0;
   logic [N*DW-1:0] req_data = '0;
   logic            pop_req  = 1'b0;
   logic            stk_wait = 1'b0;
   logic [N-1:0]    gnt;
   logic            stk_en;
   logic [1:0]      stk_ctl;
   logic [DW-1:0]   stk_data;
   logic            pop_ack;
   logic [1:0]      occupancy;
   logic            busy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   addr_stack_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .STACK_SIZE(SS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .req_dual  (req_dual),
      .req_data  (req_data),
      .pop_req   (pop_req),
      .stk_wait  (stk_wait),
      .gnt       (gnt),
      .stk_en    (stk_en),
      .stk_ctl   (stk_ctl),
      .stk_data  (stk_data),
      .pop_ack   (pop_ack),
      .occupancy (occupancy),
      .busy      (busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp_v);
      end
   endtask

   // ---------------- reference model ----------------
   int            m_occ   = 0;
   int            m_ptr   = 0;
   int            m_byp   = 0;
   bit            m_armed = 1'b0;
   logic [N-1:0]  prev_gnt;
   logic [N-1:0]  exp_gnt  = '0;
   logic          exp_en   = 1'b0;
   logic          exp_ack  = 1'b0;
   logic [1:0]    exp_ctl  = 2'b00;
   logic [DW-1:0] exp_data = '0;
   logic          exp_busy = 1'b0;
   int            order[$];
   int            pick;
   int            need;
   int            free_slots;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_occ = 0; m_ptr = 0; m_byp = 0; m_armed = 1'b0;
         exp_gnt = '0; exp_en = 1'b0; exp_ack = 1'b0; exp_ctl = 2'b00;
         exp_data = '0; exp_busy = 1'b0;
      end else begin
         prev_gnt = exp_gnt;
         exp_gnt = '0; exp_en = 1'b0; exp_ack = 1'b0; exp_ctl = 2'b00; exp_data = '0;
         pick = -1;
         if (!m_armed) begin
            m_armed = 1'b1;
         end else if (!stk_wait) begin
            order.delete();
            for (int k = 0; k < N; k++)
               if (req[(m_ptr + k) % N] && !prev_gnt[(m_ptr + k) % N]) order.push_back((m_ptr + k) % N);
            free_slots = SS - m_occ;
            if (pop_req && m_occ > 0) begin
               exp_en = 1'b1; exp_ack = 1'b1; exp_ctl = 2'b00; m_occ--;
            end else if (order.size() > 0) begin
               if ((req_dual[order[0]] ? 2 : 1) <= free_slots) begin
                  pick = order[0];
                  m_byp = 0;
               end
`ifdef ADDR_ARB_BYPASS_EN
               else if (req_dual[order[0]] && m_byp < 2 && free_slots >= 1) begin
                  for (int j = 1; j < order.size(); j++)
                     if (pick < 0 && !req_dual[order[j]]) pick = order[j];
                  if (pick >= 0) m_byp++;
               end
`endif
            end
            if (pick >= 0) begin
               need = req_dual[pick] ? 2 : 1;
               exp_gnt[pick] = 1'b1;
               exp_en   = 1'b1;
               exp_ctl  = (need == 2) ? 2'b11 : 2'b01;
               exp_data = req_data[pick*DW +: DW];
               m_occ   += need;
               m_ptr    = (pick + 1) % N;
            end
         end
         exp_busy = (m_occ != 0) || (req != '0);
      end
   end

   // Every-cycle comparison, away from the active edge.
   always @(negedge clk) begin
      check("gnt", 32'(gnt), 32'(exp_gnt));
      check("stk_en", 32'(stk_en), 32'(exp_en));
      check("pop_ack", 32'(pop_ack), 32'(exp_ack));
      check("occupancy", 32'(occupancy), 32'(m_occ));
      check("busy", 32'(busy), 32'(exp_busy));
      if (exp_en) begin
         check("stk_ctl", 32'(stk_ctl), 32'(exp_ctl));
         check("stk_data", 32'(stk_data), 32'(exp_data));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic set_src(input int i, input bit dual, input logic [DW-1:0] d);
      req[i]           = 1'b1;
      req_dual[i]      = dual;
      req_data[i*DW +: DW] = d;
   endtask

   // Advance to the next sampling point; granted sources withdraw.
   task automatic tick();
      @(negedge clk);
      req = req & ~gnt;
   endtask

   task automatic rand_step();
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         if (gnt[i]) begin
            if ($urandom_range(1, 0) == 1) set_src(i, $urandom_range(2, 0) == 0, DW'($urandom));
            else req[i] = 1'b0;
         end else if (!req[i] && $urandom_range(3, 0) == 0) begin
            set_src(i, $urandom_range(2, 0) == 0, DW'($urandom));
         end
      end
      if (pop_ack)       pop_req = ($urandom_range(1, 0) == 1);
      else if (!pop_req) pop_req = ($urandom_range(3, 0) == 0);
      stk_wait = ($urandom_range(7, 0) == 0);
   endtask

   task automatic drain();
      bit done;
      done     = 1'b0;
      stk_wait = 1'b0;
      pop_req  = 1'b1;
      for (int k = 0; k < 40 && !done; k++) begin
         tick();
         if (occupancy == 2'd0 && req == '0) done = 1'b1;
      end
      pop_req = 1'b0;
      check("drain_done", 32'(done), 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed + random sequence ----------------
   initial begin
      bit found;

      // Reset state and delayed first command after release.
      tick(); tick();
      check("rst_occ", 32'(occupancy), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_en", 32'(stk_en), 32'd0);
      for (int i = 0; i < N; i++) set_src(i, 1'b0, DW'(16'hA000 + i));
      #1 rst_n = 1'b1;
      tick();
      check("rel_gnt", 32'(gnt), 32'd0);
      check("rel_en", 32'(stk_en), 32'd0);

      // Round-robin with pops in between.
      for (int n = 0; n < 5; n++) begin
         tick();
         check("rr_gnt", 32'(gnt), 32'(1 << (n % 4)));
         check("rr_ctl", 32'(stk_ctl), 32'd1);
         check("rr_data", 32'(stk_data), 32'(16'hA000 + n));
         pop_req = 1'b1;
         if (n == 3) set_src(0, 1'b0, 16'hA004);
         tick();
         check("rr_pop_ack", 32'(pop_ack), 32'd1);
         check("rr_pop_occ", 32'(occupancy), 32'd0);
         pop_req = 1'b0;
         if (n == 4) check("rr_busy_idle", 32'(busy), 32'd0);
      end

      // Full stack: third push fills it, a fourth waits for a pop.
      set_src(0, 1'b0, 16'hB000);
      set_src(1, 1'b0, 16'hB001);
      set_src(2, 1'b0, 16'hB002);
      tick(); tick(); tick();
      check("full_gnt", 32'(gnt), 32'b0001);
      check("full_occ", 32'(occupancy), 32'd3);
      set_src(2, 1'b0, 16'hC002);
      tick(); tick();
      check("full_nognt", 32'(gnt), 32'd0);
      check("full_noen", 32'(stk_en), 32'd0);
      pop_req = 1'b1;
      tick();
      check("full_pop_ack", 32'(pop_ack), 32'd1);
      check("full_pop_occ", 32'(occupancy), 32'd2);
      pop_req = 1'b0;
      tick();
      check("full_gnt2", 32'(gnt), 32'b0100);
      check("full_data2", 32'(stk_data), 32'hC002);
      check("full_occ3", 32'(occupancy), 32'd3);
      drain();

      // Dual head blocked at occupancy 2.
      set_src(3, 1'b0, 16'hD003); tick();
      set_src(1, 1'b0, 16'hD001); tick();
      check("dual_pre_occ", 32'(occupancy), 32'd2);
      set_src(0, 1'b1, 16'hE000);
      set_src(1, 1'b0, 16'hE001);
      tick(); tick();
`ifndef ADDR_ARB_BYPASS_EN
      check("dual_block_gnt", 32'(gnt), 32'd0);
      check("dual_block_occ", 32'(occupancy), 32'd2);
`else
      check("dual_bypass_gnt", 32'(gnt), 32'b0010);
`endif
      pop_req = 1'b1; tick();
      pop_req = 1'b0; tick();
`ifndef ADDR_ARB_BYPASS_EN
      check("dual_gnt", 32'(gnt), 32'b0001);
      check("dual_ctl", 32'(stk_ctl), 32'd3);
      check("dual_data", 32'(stk_data), 32'hE000);
      check("dual_occ", 32'(occupancy), 32'd3);
`endif
      drain();

      // Stall holds everything; the pending pop goes first afterwards.
      set_src(2, 1'b0, 16'hF002); tick();
      check("stall_pre_occ", 32'(occupancy), 32'd1);
      stk_wait = 1'b1; pop_req = 1'b1; set_src(3, 1'b0, 16'hF003);
      for (int k = 0; k < 3; k++) begin
         tick();
         check("stall_en", 32'(stk_en), 32'd0);
         check("stall_gnt", 32'(gnt), 32'd0);
         check("stall_occ", 32'(occupancy), 32'd1);
      end
      stk_wait = 1'b0;
      tick();
      check("stall_pop_ack", 32'(pop_ack), 32'd1);
      check("stall_pop_ctl", 32'(stk_ctl), 32'd0);
      check("stall_pop_occ", 32'(occupancy), 32'd0);
      pop_req = 1'b0; tick();
      check("stall_push_gnt", 32'(gnt), 32'b1000);
      pop_req = 1'b1; tick();
      check("stall_push_pop", 32'(occupancy), 32'd0);

      // Underflow guard: pop on empty is ignored, push then pop.
      tick();
      check("uf_no_ack", 32'(pop_ack), 32'd0);
      check("uf_no_en", 32'(stk_en), 32'd0);
      set_src(1, 1'b0, 16'hF001);
      tick();
      check("uf_push_gnt", 32'(gnt), 32'b0010);
      check("uf_push_occ", 32'(occupancy), 32'd1);
      tick();
      check("uf_pop_ack", 32'(pop_ack), 32'd1);
      check("uf_pop_occ", 32'(occupancy), 32'd0);
      pop_req = 1'b0;

      // Random traffic.
      for (int k = 0; k < 1500; k++) rand_step();

      // Reset in the middle of a grant.
      found = 1'b0;
      for (int k = 0; k < 200 && !found; k++) begin
         rand_step();
         if (gnt != '0) found = 1'b1;
      end
      check("mid_found_grant", 32'(found), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_gnt", 32'(gnt), 32'd0);
      check("mid_rst_en", 32'(stk_en), 32'd0);
      check("mid_rst_occ", 32'(occupancy), 32'd0);
      tick(); tick();
      stk_wait = 1'b0; pop_req = 1'b0;
      if (req == '0) set_src(0, 1'b0, 16'h1234);
      #1 rst_n = 1'b1;
      tick();
      check("mid_rel_gnt", 32'(gnt), 32'd0);
      check("mid_rel_en", 32'(stk_en), 32'd0);

      for (int k = 0; k < 1500; k++) rand_step();
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/addr_stack_arbiter.md
Name: addr_stack_arbiter

Overview:
- Shares one 3-deep address stack (stack-machine address path) between NUM_REQ spike-address sources and one address consumer.
- Issues exactly one stack command per cycle: push-single, push-dual or pop.
- Keeps a mirror of stack occupancy so it never overflows or underflows the stack.
- Round-robin fairness between sources; pop has priority over pushes.

Parameters:
- NUM_REQ, 4, number of requesting sources (2..8).
- DATA_WIDTH, 16, address word width; must match the stack.
- STACK_SIZE, 3, stack depth used for the occupancy limit.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-source request; held until granted.
- req_dual  in  NUM_REQ  per-source flag: 1 = two-address packet (push-dual).
- req_data  in  NUM_REQ*DATA_WIDTH  per-source packet; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- pop_req  in  1  consumer requests one address.
- stk_wait  in  1  stack stall/full indication.
- gnt  out  NUM_REQ  one-hot, one-cycle grant pulse.
- stk_en  out  1  command strobe; stk_ctl and stk_data are valid only when stk_en=1.
- stk_ctl  out  2  stack command: 00 pop, 01 push-single, 11 push-dual; 10 is never driven.
- stk_data  out  DATA_WIDTH  packet of the granted source.
- pop_ack  out  1  pulse coinciding with a pop command.
- occupancy  out  2  mirrored stack fill level (0..STACK_SIZE).
- busy  out  1  high when occupancy != 0 or any req is pending.

Behaviour:
- Reset (rst_n=0, async): gnt=0, stk_en=0, stk_ctl=00, stk_data=0, pop_ack=0, occupancy=0, busy=0, rr_ptr=0.
- Reset mid-operation aborts any command in flight: no grant or strobe is emitted on the cycle after release.
- All outputs are registered.
  - Decision uses the inputs sampled at edge N; gnt, stk_en, stk_ctl, stk_data and pop_ack appear after edge N (1-cycle latency).
- Source handshake: a source drops req (or presents its next packet) in the cycle it sees gnt[i]=1.
  - The arbiter masks a source whose gnt is currently high from eligibility, so a held req is never granted twice.
- Decision priority each cycle:
  1. If stk_wait=1: issue nothing (stk_en=0, gnt=0, pop_ack=0); occupancy holds.
  2. Else if pop_req=1 and occupancy>0: stk_ctl=00, stk_en=1, pop_ack=1, occupancy-1.
  3. Else round-robin push:
     - Scan sources starting at rr_ptr; the head is the first source with req=1 (not masked).
     - Head fits if (req_dual=0 and occupancy<=STACK_SIZE-1) or (req_dual=1 and occupancy<=STACK_SIZE-2).
     - If the head fits: gnt[head]=1, stk_en=1, stk_ctl=01 (single) or 11 (dual), stk_data=head packet, occupancy +1 or +2, rr_ptr=head+1 mod NUM_REQ.
     - If the head does not fit: no push issued (no-bypass rule); rr_ptr unchanged.
  4. Else idle: stk_en=0.
- pop_req with occupancy=0: ignored, no pop_ack; the consumer keeps pop_req asserted.
- Push and pop never occur in the same cycle.
- Occupancy saturation:
  - Never exceeds STACK_SIZE and never goes below 0.
  - If a computed update would violate either bound, the command is suppressed instead.
- busy is registered from the post-update occupancy and the sampled req vector.

Optional Feature:
- Macro ADDR_ARB_BYPASS_EN.
- When defined: if the head is a dual request that does not fit, the scan continues from head+1 and grants the first fitting single request.
  - rr_ptr is then set to grantee+1 and the blocked dual head keeps its turn.
  - A bypass counter limits consecutive bypasses to 2; after that the no-bypass rule applies until the dual head is granted.
- When undefined: strict no-bypass as in Behaviour step 3.

Test Plan:
- Reset/idle: assert rst_n=0 mid-grant, release -> all outputs 0, occupancy=0, first command no earlier than 2 cycles after release.
- Round-robin: req=4'b1111, all single, pop_req pulses between pushes -> gnt order 0001,0010,0100,1000,0001; stk_ctl=01 each time; stk_data equals the granted slice.
- Full stack: three single pushes (occupancy=3), then req[2]=1 single -> no gnt until pop_req=1 gives pop_ack, occupancy 2, then gnt[2], occupancy 3.
- Dual blocking: occupancy=2, req[0] dual and req[1] single -> no grant (macro off).
  - With ADDR_ARB_BYPASS_EN: gnt[1] is issued; after 2 bypasses with occupancy refilled, gnt[0] is issued with stk_ctl=11 once occupancy<=1.
- Stall: stk_wait=1 for 3 cycles with req and pop_req high -> stk_en=0 and gnt=0 for those cycles, occupancy unchanged; the pop is issued the first cycle after stk_wait drops.
- Underflow guard: occupancy=0, pop_req=1 -> no pop_ack, stk_en=0; a push then a pop yields occupancy 1 then 0.
